// File: rtl/ctrl_pkg.sv
// Shared control-pipeline definitions: bundle bit map, ALU op and
// forward-select encodings, stage register structs and ID decode.
package ctrl_pkg;

  localparam int CS_W        = 10;
  localparam int REG_W       = 5;
  localparam int CNT_W       = 16;

  localparam int CS_REGWRITE = 0;
  localparam int CS_MEMTOREG = 1;
  localparam int CS_MEMWRITE = 2;
  localparam int CS_MEMREAD  = 3;
  localparam int CS_ALUSRC   = 4;
  localparam int CS_ALUOP_LO = 5;
  localparam int CS_ALUOP_HI = 6;
  localparam int CS_REGDST   = 7;
  localparam int CS_BRANCH   = 8;
  localparam int CS_JUMP     = 9;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic             alu_src;
    aluop_e           alu_op;
    logic             branch;
    logic             jump;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wreg;
  } id_ex_t;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] wreg;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] wreg;
  } mem_wb_t;

  // Destination register is resolved here so later stages
  // only carry a single write index.
  function automatic id_ex_t decode(
    input logic [CS_W-1:0]  cs,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd
  );
    id_ex_t r;
    r.alu_src    = cs[CS_ALUSRC];
    r.alu_op     = aluop_e'(cs[CS_ALUOP_HI:CS_ALUOP_LO]);
    r.branch     = cs[CS_BRANCH];
    r.jump       = cs[CS_JUMP];
    r.mem_read   = cs[CS_MEMREAD];
    r.mem_write  = cs[CS_MEMWRITE];
    r.reg_write  = cs[CS_REGWRITE];
    r.mem_to_reg = cs[CS_MEMTOREG];
    r.rs         = rs;
    r.rt         = rt;
    r.wreg       = cs[CS_REGDST] ? rd : rt;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Load-use hazard detection and EX operand forwarding (combinational).
// In: ID fields, flush, EX/MEM/WB regs. Out: stall, bubble, fwd_a/b.
module hazard_fwd_unit
  import ctrl_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_wreg,
  output logic             stall,
  output logic             bubble,
  output fwd_e             fwd_a,
  output fwd_e             fwd_b
);

  logic hazard;

  // MEM is the younger producer, so it wins a double match.
  function automatic fwd_e sel(
    input logic [REG_W-1:0] src
  );
    fwd_e f;
    f = FWD_RF;
    if (mem_reg_write && mem_wreg != '0
        && mem_wreg == src)
      f = FWD_MEM;
    else if (wb_reg_write && wb_wreg != '0
             && wb_wreg == src)
      f = FWD_WB;
    return f;
  endfunction

  always_comb begin
    hazard = id_valid && ex_mem_read
          && ex_rt != '0
          && (ex_rt == id_rs || ex_rt == id_rt);
    // A flush kills the consumer, so there is nothing to hold.
    stall  = hazard && !flush;
    bubble = flush || !id_valid || hazard;
    fwd_a  = sel(ex_rs);
    fwd_b  = sel(ex_rt);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with stall counter.
// In: decoded bundle, reg fields, flush. Out: stage controls, fwd, stall.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CS_W-1:0]  Control_Signals,
  input  logic             ID_Valid,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic [REG_W-1:0] ID_Rd,
  input  logic             Flush,
  output logic             Stall,
  output logic             EX_AluSrc,
  output logic [1:0]       EX_AluOp,
  output logic             EX_Branch,
  output logic             EX_Jump,
  output logic             MEM_MemRead,
  output logic             MEM_MemWrite,
  output logic             WB_RegWrite,
  output logic             WB_MemtoReg,
  output logic [REG_W-1:0] WB_WriteReg,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] Stall_Count
);

  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic bubble;
  fwd_e fwd_a, fwd_b;

  hazard_fwd_unit u_hfu (
    .id_valid      (ID_Valid),
    .id_rs         (ID_Rs),
    .id_rt         (ID_Rt),
    .flush         (Flush),
    .ex_mem_read   (id_ex_q.mem_read),
    .ex_rs         (id_ex_q.rs),
    .ex_rt         (id_ex_q.rt),
    .mem_reg_write (ex_mem_q.reg_write),
    .mem_wreg      (ex_mem_q.wreg),
    .wb_reg_write  (mem_wb_q.reg_write),
    .wb_wreg       (mem_wb_q.wreg),
    .stall         (Stall),
    .bubble        (bubble),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_comb begin
    id_ex_d = '0;
    if (!bubble)
      id_ex_d = decode(Control_Signals,
                       ID_Rs, ID_Rt, ID_Rd);

    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.wreg       = id_ex_q.wreg;

    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.wreg       = ex_mem_q.wreg;

    stall_cnt_d = stall_cnt_q;
    if (Stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q     <= '0;
      ex_mem_q    <= '0;
      mem_wb_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      ex_mem_q    <= ex_mem_d;
      mem_wb_q    <= mem_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign EX_AluSrc    = id_ex_q.alu_src;
  assign EX_AluOp     = id_ex_q.alu_op;
  assign EX_Branch    = id_ex_q.branch;
  assign EX_Jump      = id_ex_q.jump;
  assign MEM_MemRead  = ex_mem_q.mem_read;
  assign MEM_MemWrite = ex_mem_q.mem_write;
  assign WB_RegWrite  = mem_wb_q.reg_write;
  assign WB_MemtoReg  = mem_wb_q.mem_to_reg;
  assign WB_WriteReg  = mem_wb_q.wreg;
  assign ForwardA     = fwd_a;
  assign ForwardB     = fwd_b;
  assign Stall_Count  = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: stalls, flush, forwarding,
// reset mid-stall and counter saturation.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  Control_Signals;
  logic        ID_Valid;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        Flush;
  logic        Stall;
  logic        EX_AluSrc;
  logic [1:0]  EX_AluOp;
  logic        EX_Branch, EX_Jump;
  logic        MEM_MemRead, MEM_MemWrite;
  logic        WB_RegWrite, WB_MemtoReg;
  logic [4:0]  WB_WriteReg;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] Stall_Count;

  int n_pass = 0;
  int n_tot  = 0;

  localparam logic [9:0] LW  = 10'h01B;
  localparam logic [9:0] ADD = 10'h0C1;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Control_Signals (Control_Signals),
    .ID_Valid        (ID_Valid),
    .ID_Rs           (ID_Rs),
    .ID_Rt           (ID_Rt),
    .ID_Rd           (ID_Rd),
    .Flush           (Flush),
    .Stall           (Stall),
    .EX_AluSrc       (EX_AluSrc),
    .EX_AluOp        (EX_AluOp),
    .EX_Branch       (EX_Branch),
    .EX_Jump         (EX_Jump),
    .MEM_MemRead     (MEM_MemRead),
    .MEM_MemWrite    (MEM_MemWrite),
    .WB_RegWrite     (WB_RegWrite),
    .WB_MemtoReg     (WB_MemtoReg),
    .WB_WriteReg     (WB_WriteReg),
    .ForwardA        (ForwardA),
    .ForwardB        (ForwardB),
    .Stall_Count     (Stall_Count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic id(input logic [9:0] cs,
                    input logic v,
                    input logic [4:0] rs,
                    input logic [4:0] rt,
                    input logic [4:0] rd,
                    input logic fl);
    Control_Signals = cs;
    ID_Valid = v;
    ID_Rs = rs;
    ID_Rt = rt;
    ID_Rd = rd;
    Flush = fl;
  endtask

  task automatic idle();
    id(10'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  function automatic logic [63:0] ex_all();
    return 64'({EX_AluSrc, EX_AluOp,
                EX_Branch, EX_Jump});
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({Stall, EX_AluSrc, EX_AluOp,
                EX_Branch, EX_Jump,
                MEM_MemRead, MEM_MemWrite,
                WB_RegWrite, WB_MemtoReg,
                WB_WriteReg, ForwardA,
                ForwardB, Stall_Count});
  endfunction

  initial begin
    // reset with busy inputs
    rst_n = 1'b0;
    id(10'h3FF, 1'b1, 5'd2, 5'd2, 5'd2, 1'b0);
    tick();
    tick();
    #1 chk("rst_all_zero", all_out(), 64'd0);
    rst_n = 1'b1;
    drain();

    // load-use: LW r2 then ADD rs=2
    id(LW, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    #1 chk("lu_no_stall_lw", 64'(Stall), 64'd0);
    tick();
    id(ADD, 1'b1, 5'd2, 5'd4, 5'd5, 1'b0);
    #1 chk("lu_stall", 64'(Stall), 64'd1);
    chk("lu_ex_lw", ex_all(), 64'b10000);
    tick();
    #1 chk("lu_stall_drop", 64'(Stall), 64'd0);
    chk("lu_ex_bubble", ex_all(), 64'd0);
    chk("lu_mem_lw", 64'(MEM_MemRead), 64'd1);
    chk("lu_count", 64'(Stall_Count), 64'd1);
    tick();
    idle();
    #1 chk("lu_ex_add", 64'(EX_AluOp), 64'd2);
    chk("lu_fwd_wb", 64'(ForwardA), 64'd1);
    chk("lu_wb", 64'({WB_RegWrite, WB_MemtoReg,
                     WB_WriteReg}), 64'h62);
    drain();

    // ADD r3 -> SUB rs=3 adjacent
    id(ADD, 1'b1, 5'd1, 5'd4, 5'd3, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd3, 5'd6, 5'd7, 1'b0);
    tick();
    idle();
    #1 chk("fwd_mem_a", 64'(ForwardA), 64'd2);
    chk("fwd_mem_b", 64'(ForwardB), 64'd0);
    drain();

    // one unrelated instruction between
    id(ADD, 1'b1, 5'd1, 5'd4, 5'd3, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd8, 5'd9, 5'd10, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd3, 5'd6, 5'd7, 1'b0);
    tick();
    idle();
    #1 chk("fwd_wb_a", 64'(ForwardA), 64'd1);
    drain();

    // hazard with flush in same cycle
    id(LW, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id(10'h3C1, 1'b1, 5'd2, 5'd4, 5'd5, 1'b1);
    #1 chk("flush_stall", 64'(Stall), 64'd0);
    tick();
    idle();
    #1 chk("flush_ex_zero", ex_all(), 64'd0);
    chk("flush_count", 64'(Stall_Count), 64'd1);
    drain();

    // hazard pattern but ID not valid
    id(LW, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id(ADD, 1'b0, 5'd2, 5'd4, 5'd5, 1'b0);
    #1 chk("inval_stall", 64'(Stall), 64'd0);
    tick();
    idle();
    #1 chk("inval_ex_zero", ex_all(), 64'd0);
    drain();

    // r0 is never forwarded
    id(ADD, 1'b1, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    idle();
    #1 chk("r0_fwd", 64'({ForwardA, ForwardB}),
           64'd0);
    drain();

    // MEM and WB both write r5
    id(ADD, 1'b1, 5'd1, 5'd4, 5'd5, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd6, 5'd7, 5'd5, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd5, 5'd5, 5'd8, 1'b0);
    tick();
    idle();
    #1 chk("dbl_fwd", 64'({ForwardA, ForwardB}),
           64'hA);
    drain();

    // reset pulsed during a stall
    id(LW, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id(ADD, 1'b1, 5'd2, 5'd4, 5'd5, 1'b0);
    #1 chk("rs_stall", 64'(Stall), 64'd1);
    rst_n = 1'b0;
    #1 chk("rs_all_zero", all_out(), 64'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("rs_post_stall", 64'(Stall), 64'd0);
    chk("rs_post_count", 64'(Stall_Count), 64'd0);
    drain();

    // saturation: preload then back-to-back stalls
    force dut.stall_cnt_q = 16'hFFFC;
    #1 release dut.stall_cnt_q;
    id(LW, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0);
    repeat (4) tick();
    #1 chk("sat_fffe", 64'(Stall_Count), 64'hFFFE);
    repeat (6) tick();
    #1 chk("sat_ffff", 64'(Stall_Count), 64'hFFFF);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
